// File: rtl/score_keeper.sv
// Snake game score keeper: 3-digit BCD current and high score with active-low
// 7-segment drivers. The current-score digits blink after a new high score.
module score_keeper #(
    parameter int unsigned BLINK_CYCLES = 12_500_000,
    parameter bit          BLANK_LZ     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        score_inc,
    input  logic        new_game,
    input  logic        game_over,
    output logic [11:0] score_bcd,
    output logic [11:0] high_bcd,
    output logic        new_high,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5
);

    localparam int unsigned CntW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(BLINK_CYCLES - 1);
    localparam logic [11:0] ScoreMax = 12'h999;
    localparam logic [6:0]  SegDark  = 7'h7F;
    localparam logic [6:0]  SegZero  = 7'h40;
    // Leading digits of a cleared field are dark when blanking is enabled
    localparam logic [6:0]  SegLead0 = BLANK_LZ ? SegDark : SegZero;

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes stay dark
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SegDark;
        endcase
        return s;
    endfunction

    // Ripple-carry BCD increment; caller guarantees the input is below 999
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd9) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4]  = 4'd0;
                r[11:8] = v[11:8] + 4'd1;
            end
        end
        return r;
    endfunction

    logic [11:0]     score_q, score_d;
    logic [11:0]     high_q, high_d;
    logic            new_high_q, new_high_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            phase_on_q, phase_on_d;
    logic [6:0]      hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d;
    logic [6:0]      hex3_q, hex3_d, hex4_q, hex4_d, hex5_q, hex5_d;

    // Score and high-score next state: new_game beats score_inc
    always_comb begin
        score_d    = score_q;
        high_d     = high_q;
        new_high_d = new_high_q;
        if (new_game) begin
            score_d    = '0;
            new_high_d = 1'b0;
        end else if (score_inc && !game_over) begin
            if (score_q != ScoreMax) begin
                score_d = bcd_inc(score_q);
            end
            // BCD ordering matches numeric ordering, so a plain compare works
            if (score_d > high_q) begin
                high_d     = score_d;
                new_high_d = 1'b1;
            end
        end
    end

    // Blink timer runs only while a new high score is being celebrated
    always_comb begin
        cnt_d      = cnt_q;
        phase_on_d = phase_on_q;
        if (!new_high_q) begin
            cnt_d      = '0;
            phase_on_d = 1'b1;
        end else if (cnt_q == CntLast) begin
            cnt_d      = '0;
            phase_on_d = !phase_on_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Display next state from the registered scores, with leading-zero blanking
    always_comb begin
        hex0_d = seg7(score_q[3:0]);
        hex1_d = (BLANK_LZ && score_q[11:4] == 8'h00) ? SegDark : seg7(score_q[7:4]);
        hex2_d = (BLANK_LZ && score_q[11:8] == 4'h0) ? SegDark : seg7(score_q[11:8]);
        hex3_d = seg7(high_q[3:0]);
        hex4_d = (BLANK_LZ && high_q[11:4] == 8'h00) ? SegDark : seg7(high_q[7:4]);
        hex5_d = (BLANK_LZ && high_q[11:8] == 4'h0) ? SegDark : seg7(high_q[11:8]);
        if (!phase_on_q) begin
            hex0_d = SegDark;
            hex1_d = SegDark;
            hex2_d = SegDark;
        end
    end

    // State registers; reset loads the display of an all-zero score directly
    always_ff @(posedge clk) begin
        if (reset) begin
            score_q    <= '0;
            high_q     <= '0;
            new_high_q <= 1'b0;
            cnt_q      <= '0;
            phase_on_q <= 1'b1;
            hex0_q     <= SegZero;
            hex1_q     <= SegLead0;
            hex2_q     <= SegLead0;
            hex3_q     <= SegZero;
            hex4_q     <= SegLead0;
            hex5_q     <= SegLead0;
        end else begin
            score_q    <= score_d;
            high_q     <= high_d;
            new_high_q <= new_high_d;
            cnt_q      <= cnt_d;
            phase_on_q <= phase_on_d;
            hex0_q     <= hex0_d;
            hex1_q     <= hex1_d;
            hex2_q     <= hex2_d;
            hex3_q     <= hex3_d;
            hex4_q     <= hex4_d;
            hex5_q     <= hex5_d;
        end
    end

    assign score_bcd = score_q;
    assign high_bcd  = high_q;
    assign new_high  = new_high_q;
    assign HEX0      = hex0_q;
    assign HEX1      = hex1_q;
    assign HEX2      = hex2_q;
    assign HEX3      = hex3_q;
    assign HEX4      = hex4_q;
    assign HEX5      = hex5_q;

endmodule
